pid_seq: RTL
============

Name: pid_seq

Overview:
- Multi-cycle, resource-shared PID controller for the Knights Tour drive path.
- Accepts one heading-error sample per err_vld and computes P, I and D terms in sequence through a single shared signed multiplier.
- Produces registered lft_spd/rght_spd with a one-cycle spd_vld strobe to the motor driver.
- Replaces the combinational PID to cut multiplier area and the long timing path.

Parameters:
- P_COEFF, 6'sh08: proportional coefficient (signed).
- D_COEFF, 6'sh0B: derivative coefficient (signed).
- D_DEPTH, 2: number of accepted samples back used as the D-term "previous error" (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- moving  in  1  robot moving; low clears integrator and forces speeds to 0
- err_vld  in  1  one-cycle strobe: error is valid
- error  in  12  signed heading error
- frwrd  in  10  unsigned forward speed, sampled at acceptance
- busy  out  1  high while a computation is in flight
- err_drop  out  1  one-cycle pulse when err_vld arrives while busy (sample discarded)
- spd_vld  out  1  one-cycle pulse: new lft_spd/rght_spd registered
- lft_spd  out  11  signed left speed, registered
- rght_spd  out  11  signed right speed, registered

Behaviour:
- Reset: FSM=IDLE; integrator, history, P/D/accumulator registers, lft_spd, rght_spd all 0; busy, err_drop, spd_vld all 0.
- FSM states: IDLE -> MUL_P -> MUL_D -> INTEG -> SUM -> OUT -> IDLE; one cycle per state.
- IDLE: on err_vld && moving, accept the sample:
  - latch err_sat (error saturated to 10 bits: <-512 -> 0x200, >511 -> 0x1FF) and frwrd;
  - shift err_sat into the history;
  - set busy.
- err_vld in IDLE with moving low: ignored, no spd_vld.
- MUL_P: shared multiplier computes err_sat*P_COEFF; result stored as 14-bit P.
- MUL_D:
  - D_diff = err_sat - hist[D_DEPTH] (10-bit), saturated to 7 bits (-64..63);
  - times D_COEFF, stored as 13-bit D.
  - Until D_DEPTH samples have been accepted, the missing history entries read 0.
- INTEG:
  - sum = integrator + sign-extended err_sat (15-bit);
  - on signed overflow (both addends share a sign, sum's sign differs), integrator holds; otherwise integrator = sum;
  - I = integrator[14:6] after the update (9-bit).
- SUM: PID = P + sext(I) + sext(D), 14-bit.
- OUT:
  - lft = {0,frwrd} + PID[13:3]; rght = {0,frwrd} - PID[13:3];
  - if the added term is non-negative and bit10 of the result is set, saturate to 0x3FF;
  - no negative clamp: negative results are legal signed speeds;
  - register both, pulse spd_vld, drop busy, return to IDLE.
- Latency: err_vld accepted at cycle 0 -> spd_vld high in cycle 5. Max throughput is 1 sample per 6 cycles.
- err_vld while busy: sample discarded; err_drop pulses the same cycle; no state change.
- moving low in any state, sampled each clock:
  - next clock: integrator = 0, lft_spd = rght_spd = 0, FSM -> IDLE, busy = 0;
  - the in-flight result is discarded with no spd_vld;
  - history is retained.
- Reset asserted mid-operation: immediate return to the reset values above.
- The single multiplier is the only multiplier instance; its operand mux is selected by FSM state.

Decomposition:
- Shared package pid_pkg holds:
  - the FSM state enum (IDLE, MUL_P, MUL_D, INTEG, SUM, OUT);
  - widths ERR_W=10, INTEG_W=15, PID_W=14, SPD_W=11;
  - the saturation constants.
- Sub-module pid_mul: signed 10x6 multiplier plus operand mux, shared across states.

Test Plan:
- After reset, error=12'h040, frwrd=0x100, moving=1, err_vld pulse -> spd_vld at cycle 5; P=512, D=693 (diff sat 63), I=1, PID=1206, lft_spd=0x196, rght_spd=0x06A.
- After reset, error=12'h7FF, frwrd=0x3FF -> lft_spd saturates to 0x3FF, rght_spd=0x1A9.
- After reset, error=12'h800, frwrd=0x100 -> PID=-4808, lft_spd=0x6A7 (-345), rght_spd=0x359.
- After reset, 33 consecutive accepted samples of error=0x1FF -> integrator freezes at 16352 on the 33rd sample; I=255.
- err_vld at cycles 0 and 2 -> err_drop pulses at cycle 2; exactly one spd_vld, at cycle 5.
- Drop moving in MUL_D state -> next cycle busy=0, lft_spd=rght_spd=0, integrator=0, no spd_vld.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types, widths and saturation helpers for the resource-shared PID.
package pid_pkg;

    localparam int unsigned ERR_IN_W  = 12;
    localparam int unsigned ERR_W     = 10;
    localparam int unsigned DIFF_IN_W = ERR_W + 1;
    localparam int unsigned DIFF_W    = 7;
    localparam int unsigned FRWRD_W   = 10;
    localparam int unsigned COEFF_W   = 6;
    localparam int unsigned MUL_W     = ERR_W + COEFF_W;
    localparam int unsigned P_W       = 14;
    localparam int unsigned D_W       = 13;
    localparam int unsigned INTEG_W   = 15;
    localparam int unsigned I_W       = 9;
    localparam int unsigned PID_W     = 14;
    localparam int unsigned SPD_W     = 11;

    localparam logic signed [ERR_W-1:0]  ERR_POS_SAT  = 10'sh1FF;
    localparam logic signed [ERR_W-1:0]  ERR_NEG_SAT  = 10'sh200;
    localparam logic signed [DIFF_W-1:0] DIFF_POS_SAT = 7'sh3F;
    localparam logic signed [DIFF_W-1:0] DIFF_NEG_SAT = 7'sh40;
    localparam logic [SPD_W-1:0]         SPD_POS_SAT  = 11'h3FF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_D = 3'd2,
        INTEG = 3'd3,
        SUM   = 3'd4,
        OUT   = 3'd5
    } pid_state_e;

    // Clamp the raw 12-bit heading error into the 10-bit working range.
    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [ERR_IN_W-1:0] e);
        if (e[ERR_IN_W-1:ERR_W-1] == {(ERR_IN_W-ERR_W+1){e[ERR_IN_W-1]}}) begin
            return ERR_W'(e);
        end
        return e[ERR_IN_W-1] ? ERR_NEG_SAT : ERR_POS_SAT;
    endfunction

    // Clamp the 11-bit error difference into the 7-bit derivative range.
    function automatic logic signed [DIFF_W-1:0] sat_diff(input logic signed [DIFF_IN_W-1:0] d);
        if (d[DIFF_IN_W-1:DIFF_W-1] == {(DIFF_IN_W-DIFF_W+1){d[DIFF_IN_W-1]}}) begin
            return DIFF_W'(d);
        end
        return d[DIFF_IN_W-1] ? DIFF_NEG_SAT : DIFF_POS_SAT;
    endfunction

endpackage

// File: rtl/pid_mul.sv
// Single shared signed multiplier; the FSM state picks the operand pair.
//   state   : current PID FSM state (MUL_D selects the derivative operands)
//   err_sat : saturated error, proportional operand
//   d_diff  : saturated error difference, derivative operand
//   prod_c  : combinational product, truncated to the P-term width
module pid_mul
    import pid_pkg::*;
#(
    parameter logic signed [COEFF_W-1:0] P_COEFF = 6'sh08,
    parameter logic signed [COEFF_W-1:0] D_COEFF = 6'sh0B
) (
    input  pid_state_e               state,
    input  logic signed [ERR_W-1:0]  err_sat,
    input  logic signed [DIFF_W-1:0] d_diff,
    output logic signed [P_W-1:0]    prod_c
);

    logic signed [ERR_W-1:0]   op_a;
    logic signed [COEFF_W-1:0] op_b;

    // Operand mux: derivative pair in MUL_D, proportional pair otherwise.
    always_comb begin
        op_a = err_sat;
        op_b = P_COEFF;
        if (state == MUL_D) begin
            op_a = ERR_W'(d_diff);
            op_b = D_COEFF;
        end
    end

    // With the configured coefficients the product magnitude stays inside P_W bits.
    assign prod_c = P_W'(MUL_W'(op_a) * MUL_W'(op_b));

endmodule

// File: rtl/pid_seq.sv
// Multi-cycle PID for the drive path: P, D via one shared multiplier, then
// integrator, sum and speed mix, one FSM state per step.
//   clk, rst_n : clock, async active-low reset
//   moving     : low clears integrator/speeds and aborts any computation
//   err_vld    : error sample strobe; error (12b signed), frwrd (10b unsigned)
//   busy       : computation in flight
//   err_drop   : combinational pulse when err_vld arrives while busy
//   spd_vld    : one-cycle strobe with new lft_spd / rght_spd (11b signed)
module pid_seq
    import pid_pkg::*;
#(
    parameter logic signed [COEFF_W-1:0] P_COEFF = 6'sh08,
    parameter logic signed [COEFF_W-1:0] D_COEFF = 6'sh0B,
    parameter int unsigned               D_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                moving,
    input  logic                err_vld,
    input  logic [ERR_IN_W-1:0] error,
    input  logic [FRWRD_W-1:0]  frwrd,
    output logic                busy,
    output logic                err_drop,
    output logic                spd_vld,
    output logic [SPD_W-1:0]    lft_spd,
    output logic [SPD_W-1:0]    rght_spd
);

    pid_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic       spd_vld_q, spd_vld_d;

    logic signed [ERR_W-1:0]   err_sat_q, err_sat_d;
    logic [FRWRD_W-1:0]        frwrd_q, frwrd_d;
    // hist_q[k] is the sample accepted k samples before err_sat_q.
    logic signed [ERR_W-1:0]   hist_q [1:D_DEPTH];
    logic signed [ERR_W-1:0]   hist_d [1:D_DEPTH];
    logic signed [P_W-1:0]     p_q, p_d;
    logic signed [D_W-1:0]     d_q, d_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [I_W-1:0]     i_q, i_d;
    logic signed [PID_W-1:0]   acc_q, acc_d;
    logic signed [SPD_W-1:0]   lft_q, lft_d;
    logic signed [SPD_W-1:0]   rght_q, rght_d;

    logic                      accept_c;
    logic signed [DIFF_W-1:0]  d_diff_c;
    logic signed [P_W-1:0]     prod_c;
    logic signed [INTEG_W-1:0] integ_sum_c;
    logic                      integ_ovf_c;
    logic signed [INTEG_W-1:0] integ_next_c;
    logic signed [PID_W-1:0]   pid_c;
    logic signed [SPD_W-1:0]   pid_sh_c;
    logic signed [SPD_W-1:0]   frwrd_ext_c;
    logic signed [SPD_W-1:0]   lft_sum_c;
    logic signed [SPD_W-1:0]   rght_sum_c;

    pid_mul #(
        .P_COEFF (P_COEFF),
        .D_COEFF (D_COEFF)
    ) u_mul (
        .state   (state_q),
        .err_sat (err_sat_q),
        .d_diff  (d_diff_c),
        .prod_c  (prod_c)
    );

    assign accept_c = (state_q == IDLE) && err_vld && moving;
    assign d_diff_c = sat_diff(DIFF_IN_W'(err_sat_q) - DIFF_IN_W'(hist_q[D_DEPTH]));

    // Integrator holds instead of wrapping on signed overflow.
    assign integ_sum_c  = integ_q + INTEG_W'(err_sat_q);
    assign integ_ovf_c  = (integ_q[INTEG_W-1] == err_sat_q[ERR_W-1]) &&
                          (integ_sum_c[INTEG_W-1] != integ_q[INTEG_W-1]);
    assign integ_next_c = integ_ovf_c ? integ_q : integ_sum_c;

    // acc_q already holds P + D; adding I here finishes the PID sum.
    assign pid_c       = acc_q + PID_W'(i_q);
    assign pid_sh_c    = SPD_W'(pid_c >>> (PID_W - SPD_W));
    assign frwrd_ext_c = signed'({1'b0, frwrd_q});
    assign lft_sum_c   = frwrd_ext_c + pid_sh_c;
    assign rght_sum_c  = frwrd_ext_c - pid_sh_c;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        spd_vld_d = 1'b0;
        err_sat_d = err_sat_q;
        frwrd_d   = frwrd_q;
        hist_d    = hist_q;
        p_d       = p_q;
        d_d       = d_q;
        integ_d   = integ_q;
        i_d       = i_q;
        acc_d     = acc_q;
        lft_d     = lft_q;
        rght_d    = rght_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    err_sat_d = sat_err(error);
                    frwrd_d   = frwrd;
                    hist_d[1] = err_sat_q;
                    for (int unsigned k = 2; k <= D_DEPTH; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    busy_d  = 1'b1;
                    state_d = MUL_P;
                end
            end
            MUL_P: begin
                p_d     = prod_c;
                state_d = MUL_D;
            end
            MUL_D: begin
                d_d     = D_W'(prod_c);
                state_d = INTEG;
            end
            INTEG: begin
                integ_d = integ_next_c;
                i_d     = I_W'(integ_next_c >>> (INTEG_W - I_W));
                acc_d   = p_q + PID_W'(d_q);
                state_d = SUM;
            end
            SUM: begin
                // Only a non-negative added term can overflow into bit 10.
                lft_d     = (!pid_sh_c[SPD_W-1] && lft_sum_c[SPD_W-1]) ? SPD_POS_SAT : lft_sum_c;
                rght_d    = (pid_sh_c[SPD_W-1] && rght_sum_c[SPD_W-1]) ? SPD_POS_SAT : rght_sum_c;
                spd_vld_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Robot stopped: abort, clear integrator and speeds, keep history.
        if (!moving) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            spd_vld_d = 1'b0;
            integ_d   = '0;
            lft_d     = '0;
            rght_d    = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            spd_vld_q <= 1'b0;
            err_sat_q <= '0;
            frwrd_q   <= '0;
            for (int unsigned k = 1; k <= D_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            p_q       <= '0;
            d_q       <= '0;
            integ_q   <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            spd_vld_q <= spd_vld_d;
            err_sat_q <= err_sat_d;
            frwrd_q   <= frwrd_d;
            hist_q    <= hist_d;
            p_q       <= p_d;
            d_q       <= d_d;
            integ_q   <= integ_d;
            i_q       <= i_d;
            acc_q     <= acc_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
        end
    end

    assign busy     = busy_q;
    assign err_drop = err_vld & busy_q;
    assign spd_vld  = spd_vld_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;

endmodule
